data_mem_responder: RTL and testbench

- Memory-side responder for the processor's load/store interface: accepts one read or write request per handshake, serves it from an internal word array after a programmable number of wait states, and returns data plus error status.
- Sits between the datapath's memory port (mem_read, mem_write, address, store data) and on-chip data storage.
- Lets the core be tested against non-zero-latency memory.

---
 rtl/data_mem_responder.sv | 75 +++++++
 tb/tb_data_mem_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: load/store memory responder serving one request at a time
// from an internal word array after LATENCY wait states.
module data_mem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rsp_err
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic q_write, q_err;
  logic [IW-1:0] q_idx;
  logic [DATA_W-1:0] q_wdata;
  logic accept, in_err, c_write, c_err, enter;
  logic [IW-1:0] c_idx;
  logic [DATA_W-1:0] c_wdata;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign accept = req_ready && (mem_read || mem_write);
  assign in_err = addr[1:0] != 2'b0 || (addr >> (IW + 2)) != '0 || (mem_read && mem_write);
  // With zero wait states the operation happens on the accepting edge, so use the live inputs.
  assign c_write = state == IDLE ? mem_write : q_write;
  assign c_err = state == IDLE ? in_err : q_err;
  assign c_idx = state == IDLE ? addr[IW+1:2] : q_idx;
  assign c_wdata = state == IDLE ? wdata : q_wdata;
  assign enter = state_n == RESP && state != RESP;
  always_comb begin
    state_n = state == IDLE ? (accept ? (LATENCY == 0 ? RESP : WAIT) : IDLE) :
              state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) :
              state == RESP ? (rsp_ready ? IDLE : RESP) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      rdata <= '0;
      rsp_err <= 1'b0;
      q_write <= 1'b0;
      q_err <= 1'b0;
      q_idx <= '0;
      q_wdata <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        q_write <= mem_write;
        q_err <= in_err;
        q_idx <= addr[IW+1:2];
        q_wdata <= wdata;
      end
      cnt <= accept ? 4'(LATENCY) : state == WAIT ? cnt - 4'd1 : cnt;
      if (enter) begin
        rdata <= c_err || c_write ? '0 : mem[c_idx];
        rsp_err <= c_err;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && enter && c_write && !c_err) mem[c_idx] <= c_wdata;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: two responders (LATENCY 2 and 0) checked every cycle against
// a transaction-level memory model, plus directed literal scenarios.
module tb_data_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n[2], mr[2], mw[2], rsp_ready[2], rdy[2], vld[2], err[2];
  logic [15:0] addr[2];
  logic [31:0] wd[2], rd[2];
  int errors = 0, checks = 0;
  bit armed = 0;
  for (genvar g = 0; g < 2; g++) begin : lane
    data_mem_responder #(.LATENCY(g == 0 ? 2 : 0)) dut (
      .clk(clk), .rst_n(rst_n[g]), .mem_read(mr[g]), .mem_write(mw[g]),
      .addr(addr[g]), .wdata(wd[g]), .req_ready(rdy[g]), .rsp_valid(vld[g]),
      .rsp_ready(rsp_ready[g]), .rdata(rd[g]), .rsp_err(err[g]));
  end
  function automatic int lat_of(int l);
    return l == 0 ? 2 : 0;
  endfunction
  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endfunction
  // Model: an outstanding request becomes a response a fixed number of edges after acceptance.
  bit m_busy[2], m_valid[2], m_err[2], m_known[2], p_wr[2];
  int m_left[2], p_idx[2];
  logic [31:0] m_data[2], p_wd[2];
  logic [31:0] mm[2][256];
  bit kn[2][256];
  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      automatic int a = int'(addr[l]);
      automatic bit e = (a % 4 != 0) || a >= 1024 || (mr[l] && mw[l]);
      automatic int ix = (a / 4) % 256;
      if (!rst_n[l]) begin
        m_busy[l] <= 0;
        m_valid[l] <= 0;
      end else if (!m_busy[l]) begin
        if (mr[l] || mw[l]) begin
          m_busy[l] <= 1;
          m_err[l] <= e;
          m_data[l] <= (e || mw[l]) ? 32'h0 : mm[l][ix];
          m_known[l] <= e || mw[l] || kn[l][ix];
          p_wr[l] <= mw[l] && !e;
          p_idx[l] <= ix;
          p_wd[l] <= wd[l];
          m_left[l] <= lat_of(l);
          if (lat_of(l) == 0) begin
            m_valid[l] <= 1;
            if (mw[l] && !e) begin
              mm[l][ix] <= wd[l];
              kn[l][ix] <= 1;
            end
          end
        end
      end else if (!m_valid[l]) begin
        m_left[l] <= m_left[l] - 1;
        if (m_left[l] == 1) begin
          m_valid[l] <= 1;
          if (p_wr[l]) begin
            mm[l][p_idx[l]] <= p_wd[l];
            kn[l][p_idx[l]] <= 1;
          end
        end
      end else if (rsp_ready[l]) begin
        m_busy[l] <= 0;
        m_valid[l] <= 0;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (armed) for (int l = 0; l < 2; l++) begin
      chk($sformatf("req_ready[%0d]", l), 32'(rdy[l]), 32'(!m_busy[l]));
      chk($sformatf("rsp_valid[%0d]", l), 32'(vld[l]), 32'(m_valid[l]));
      if (m_valid[l]) begin
        chk($sformatf("rsp_err[%0d]", l), 32'(err[l]), 32'(m_err[l]));
        if (m_known[l]) chk($sformatf("rdata[%0d]", l), rd[l], m_data[l]);
      end
    end
  end
  task automatic issue(int l, bit r, bit w, logic [15:0] a, logic [31:0] d);
    int n = 0;
    mr[l] = r; mw[l] = w; addr[l] = a; wd[l] = d;
    while (!rdy[l] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 50), 32'd1);
    @(posedge clk);
    @(negedge clk);
    mr[l] = 0; mw[l] = 0; addr[l] = 16'($urandom); wd[l] = $urandom;
  endtask
  task automatic finish(int l, int hold, bit keep, output logic [31:0] d, output bit e, output int lat);
    lat = 1;
    while (!vld[l] && lat < 40) begin
      rsp_ready[l] = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    rsp_ready[l] = 0;
    chk("rsp_timeout", 32'(lat < 40), 32'd1);
    d = rd[l];
    e = err[l];
    if (keep) begin
      mr[l] = 1;
      addr[l] = 16'h0010;
    end
    repeat (hold) @(negedge clk);
    rsp_ready[l] = 1;
    @(negedge clk);
    rsp_ready[l] = 0;
  endtask
  task automatic xact(int l, bit r, bit w, logic [15:0] a, logic [31:0] d, int hold, bit keep,
                      logic [31:0] ed, bit ee, string nm);
    logic [31:0] gd;
    bit ge;
    int lat;
    issue(l, r, w, a, d);
    finish(l, hold, keep, gd, ge, lat);
    chk({nm, "_lat"}, 32'(lat), 32'(lat_of(l) + 1));
    chk({nm, "_err"}, 32'(ge), 32'(ee));
    chk({nm, "_data"}, gd, ed);
  endtask
  initial begin
    for (int l = 0; l < 2; l++) begin
      rst_n[l] = 0; mr[l] = 0; mw[l] = 0; rsp_ready[l] = 0; addr[l] = '0; wd[l] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n[0] = 1;
    rst_n[1] = 1;
    armed = 1;
    chk("reset_ready0", 32'(rdy[0]), 32'd1);
    chk("reset_valid0", 32'(vld[0]), 32'd0);
    chk("reset_rdata0", rd[0], 32'h0);
    chk("reset_err0", 32'(err[0]), 32'd0);
    for (int l = 0; l < 2; l++) begin
      xact(l, 0, 1, 16'h0010, 32'hDEADBEEF, 0, 0, 32'h0, 0, "wr10");
      xact(l, 1, 0, 16'h0010, 32'h0, 0, 0, 32'hDEADBEEF, 0, "rd10");
      xact(l, 1, 0, 16'h0013, 32'h0, 0, 0, 32'h0, 1, "rd13_misaligned");
      xact(l, 1, 0, 16'h0010, 32'h0, 0, 0, 32'hDEADBEEF, 0, "rd10_again");
      xact(l, 0, 1, 16'h0000, 32'hCAFE0001, 0, 0, 32'h0, 0, "wr00");
      xact(l, 0, 1, 16'h0400, 32'h12345678, 0, 0, 32'h0, 1, "wr400_range");
      xact(l, 1, 0, 16'h0000, 32'h0, 0, 0, 32'hCAFE0001, 0, "rd00");
      xact(l, 1, 0, 16'h0010, 32'h0, 5, 1, 32'hDEADBEEF, 0, "hold");
      xact(l, 1, 0, 16'h0010, 32'h0, 0, 0, 32'hDEADBEEF, 0, "after_hold");
      xact(l, 0, 1, 16'h0020, 32'h5A5A0020, 0, 0, 32'h0, 0, "wr20");
      xact(l, 1, 1, 16'h0020, 32'hAAAA5555, 0, 0, 32'h0, 1, "both20");
      xact(l, 1, 0, 16'h0020, 32'h0, 0, 0, 32'h5A5A0020, 0, "rd20");
      xact(l, 0, 1, 16'h0030, 32'h11112222, 0, 0, 32'h0, 0, "wr30");
      issue(l, 0, 1, 16'h0030, 32'h0BADF00D);
      rst_n[l] = 0;
      @(negedge clk);
      rst_n[l] = 1;
      chk("midreset_ready", 32'(rdy[l]), 32'd1);
      chk("midreset_valid", 32'(vld[l]), 32'd0);
      xact(l, 1, 0, 16'h0030, 32'h0, 0, 0, l == 0 ? 32'h11112222 : 32'h0BADF00D, 0, "rd30");
    end
    for (int l = 0; l < 2; l++) begin
      repeat (40) begin
        automatic int k = $urandom_range(0, 9);
        automatic int kind = $urandom_range(0, 5);
        automatic logic [15:0] a = 16'($urandom_range(0, 7) * 4);
        logic [31:0] gd;
        bit ge;
        int lat;
        if (kind == 0) a = a | 16'($urandom_range(1, 3));
        if (kind == 1) a = a | (16'h0400 << $urandom_range(0, 5));
        issue(l, k < 4 || k >= 8, k >= 4 && k <= 8, a, $urandom);
        finish(l, $urandom_range(0, 3), 0, gd, ge, lat);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
